// File: rtl/msoc_mem_info_master.sv
// -----------------------------------------------------------------------------
// msoc_mem_info_master
// Avalon-MM master for the single-port on-chip info memory. Runs one of two
// block commands: a read that sums every word fetched (mod 2^32), or a fill
// that writes one constant word over a range. The slave never stalls, so one
// access is issued per clock; read data returns READ_LATENCY cycles later.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   start, op           command strobe (IDLE only), 0 = read-checksum, 1 = fill
//   base_addr, length   first word address, word count (1..DEPTH)
//   fill_data           word written by a fill
//   busy, done, error   in-progress flag, completion pulse, rejection pulse
//   checksum            sum produced by the most recent read command
//   avm_*               Avalon-MM master signals towards the slave s1 port
// -----------------------------------------------------------------------------
module msoc_mem_info_master #(
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [31:0]       fill_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);

  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH-1);
  localparam logic [1:0]        DRAIN_INIT = 2'(READ_LATENCY-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_op, w_op_nxt;
  logic [31:0]             r_fill, w_fill_nxt;
  logic [ADDR_W:0]         r_cnt, w_cnt_nxt;       // accesses still to issue after the current one
  logic [1:0]              r_drain, w_drain_nxt;
  logic [READ_LATENCY-1:0] r_tag, w_tag_nxt;
  logic [31:0]             r_acc, w_acc_nxt, w_acc_sum;
  logic                    w_cs_nxt, w_wr_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
  logic [ADDR_W-1:0]       w_addr_nxt, w_addr_inc;
  logic [3:0]              w_be_nxt;
  logic [31:0]             w_wd_nxt, w_cksum_nxt;
  logic                    w_len_ok;

  // Command length check, wrapping address increment and read-tag accumulation.
  always_comb begin
    w_len_ok   = (length != '0) && (length <= DEPTH_L);
    w_addr_inc = (avm_address == LAST_ADDR) ? '0 : avm_address + ADDR_W'(1);
    // A tag enters the pipe on the edge after a read is presented to the slave
    // and reaches the last stage exactly when its data is on avm_readdata.
    w_tag_nxt    = r_tag << 1;
    w_tag_nxt[0] = avm_chipselect & ~avm_write;
    w_acc_sum    = r_acc + (r_tag[READ_LATENCY-1] ? avm_readdata : 32'd0);
  end

  // Next-state and next-output decode; every output is the registered image of this.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_fill_nxt  = r_fill;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    w_acc_nxt   = w_acc_sum;
    w_cs_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_addr_nxt  = '0;
    w_be_nxt    = 4'h0;
    w_wd_nxt    = 32'd0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_cksum_nxt = checksum;
    case (r_state)
      S_IDLE: begin
        if (start && w_len_ok) begin
          // First access is presented in the cycle right after acceptance.
          w_state_nxt = S_ISSUE;
          w_op_nxt    = op;
          w_fill_nxt  = fill_data;
          w_cnt_nxt   = length - (ADDR_W+1)'(1);
          w_acc_nxt   = 32'd0;
          w_cs_nxt    = 1'b1;
          w_wr_nxt    = op;
          w_addr_nxt  = base_addr;
          w_be_nxt    = 4'hF;
          w_wd_nxt    = fill_data;
          w_busy_nxt  = 1'b1;
        end else if (start) begin
          w_err_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt  = r_cnt - (ADDR_W+1)'(1);
          w_cs_nxt   = 1'b1;
          w_wr_nxt   = r_op;
          w_addr_nxt = w_addr_inc;
          w_be_nxt   = 4'hF;
          w_wd_nxt   = r_fill;
          w_busy_nxt = 1'b1;
        end else if (r_op) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = DRAIN_INIT;
          w_busy_nxt  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == 2'd0) begin
          // The last read word emerges on this same edge, so take the
          // sum including it rather than the stale accumulator.
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_cksum_nxt = w_acc_sum;
        end else begin
          w_drain_nxt = r_drain - 2'd1;
          w_busy_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command fields, counters, accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op           <= 1'b0;
      r_fill         <= 32'd0;
      r_cnt          <= '0;
      r_drain        <= 2'd0;
      r_tag          <= '0;
      r_acc          <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      checksum       <= 32'd0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'h0;
      avm_writedata  <= 32'd0;
    end else begin
      r_op           <= w_op_nxt;
      r_fill         <= w_fill_nxt;
      r_cnt          <= w_cnt_nxt;
      r_drain        <= w_drain_nxt;
      r_tag          <= w_tag_nxt;
      r_acc          <= w_acc_nxt;
      busy           <= w_busy_nxt;
      done           <= w_done_nxt;
      error          <= w_err_nxt;
      checksum       <= w_cksum_nxt;
      avm_address    <= w_addr_nxt;
      avm_chipselect <= w_cs_nxt;
      avm_write      <= w_wr_nxt;
      avm_byteenable <= w_be_nxt;
      avm_writedata  <= w_wd_nxt;
    end
  end

endmodule

// File: tb/tb_msoc_mem_info_master.sv
// -----------------------------------------------------------------------------
// tb_msoc_mem_info_master
// Directed bench for msoc_mem_info_master. Instance A uses READ_LATENCY=1,
// instance B uses READ_LATENCY=2; each talks to its own behavioural 256x32
// memory. Cycle n of a command is the interval after the n-th clock edge
// following the edge that samples start (cycle 1 follows edge 0).
// -----------------------------------------------------------------------------
module tb_msoc_mem_info_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start_b, op, sel;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic [31:0] fill_data;

  logic        busy_a, done_a, err_a, cs_a, wr_a;
  logic [31:0] cksum_a, wd_a, rd_a;
  logic [7:0]  addr_a;
  logic [3:0]  be_a;
  logic        busy_b, done_b, err_b, cs_b, wr_b;
  logic [31:0] cksum_b, wd_b, rd_b, rd_b1;
  logic [7:0]  addr_b;
  logic [3:0]  be_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic        pl_we_a, pl_we_b;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  msoc_mem_info_master #(.ADDR_W(8), .DEPTH(256), .READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
    .length(length), .fill_data(fill_data), .busy(busy_a), .done(done_a),
    .error(err_a), .checksum(cksum_a), .avm_address(addr_a),
    .avm_chipselect(cs_a), .avm_write(wr_a), .avm_byteenable(be_a),
    .avm_writedata(wd_a), .avm_readdata(rd_a));

  msoc_mem_info_master #(.ADDR_W(8), .DEPTH(256), .READ_LATENCY(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op(op), .base_addr(base_addr),
    .length(length), .fill_data(fill_data), .busy(busy_b), .done(done_b),
    .error(err_b), .checksum(cksum_b), .avm_address(addr_b),
    .avm_chipselect(cs_b), .avm_write(wr_b), .avm_byteenable(be_b),
    .avm_writedata(wd_b), .avm_readdata(rd_b));

  // Slave model A: one-cycle read latency, plus a bench preload port.
  always @(posedge clk) begin
    if (pl_we_a) mem_a[pl_addr] <= pl_data;
    else if (cs_a && wr_a) mem_a[addr_a] <= wd_a;
    if (cs_a && !wr_a) rd_a <= mem_a[addr_a];
  end

  // Slave model B: two-cycle read latency.
  always @(posedge clk) begin
    if (pl_we_b) mem_b[pl_addr] <= pl_data;
    else if (cs_b && wr_b) mem_b[addr_b] <= wd_b;
    if (cs_b && !wr_b) rd_b1 <= mem_b[addr_b];
    rd_b <= rd_b1;
  end

  logic        m_cs, m_wr, m_busy, m_done;
  logic [7:0]  m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_cksum;
  assign m_cs    = sel ? cs_b    : cs_a;
  assign m_wr    = sel ? wr_b    : wr_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_addr  = sel ? addr_b  : addr_a;
  assign m_be    = sel ? be_b    : be_a;
  assign m_cksum = sel ? cksum_b : cksum_a;

  int n_checks = 0;
  int n_errors = 0;
  int acc_n, done_cyc, bad_acc, done_busy, n_done, n_cs;
  logic [7:0] addr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic which, input logic [7:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    if (which) pl_we_b = 1'b1; else pl_we_a = 1'b1;
    @(posedge clk); #1;
    pl_we_a = 1'b0;
    pl_we_b = 1'b0;
  endtask

  // Issue one command and watch it cycle by cycle until done or the bound expires.
  task automatic run_cmd(input logic s, input logic o, input logic [7:0] b,
                         input logic [8:0] l, input logic [31:0] f,
                         input int bound, input int pulse_cyc);
    sel = s; op = o; base_addr = b; length = l; fill_data = f;
    if (s) start_b = 1'b1; else start = 1'b1;
    acc_n = 0; done_cyc = -1; bad_acc = 0; done_busy = -1;
    addr_q.delete();
    @(posedge clk); #1;
    start = 1'b0; start_b = 1'b0;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      if (cyc == pulse_cyc) begin
        start = 1'b1; op = ~o; base_addr = 8'h40; length = 9'd2; fill_data = 32'hDEAD0000;
      end else begin
        start = 1'b0;
      end
      if (m_cs) begin
        acc_n++;
        addr_q.push_back(m_addr);
        if (m_be !== 4'hF || m_wr !== o || m_busy !== 1'b1) bad_acc++;
      end
      if (m_done) begin
        done_cyc = cyc;
        done_busy = int'(m_busy);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_b = 1'b0; op = 1'b0; sel = 1'b0;
    base_addr = 8'h00; length = 9'd0; fill_data = 32'd0;
    pl_we_a = 1'b0; pl_we_b = 1'b0; pl_addr = 8'h00; pl_data = 32'd0;
    #12;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_error", 32'(err_a), 32'd0);
    chk("rst_checksum", cksum_a, 32'd0);
    chk("rst_cs", 32'(cs_a), 32'd0);
    chk("rst_write", 32'(wr_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_be", 32'(be_a), 32'd0);
    chk("rst_wdata", wd_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic read-checksum of four words.
    poke(1'b0, 8'h10, 32'd1); poke(1'b0, 8'h11, 32'd2);
    poke(1'b0, 8'h12, 32'd3); poke(1'b0, 8'h13, 32'd4);
    run_cmd(1'b0, 1'b0, 8'h10, 9'd4, 32'd0, 40, 0);
    chk("rd4_accesses", 32'(acc_n), 32'd4);
    chk("rd4_addr_first", 32'(addr_q[0]), 32'h10);
    chk("rd4_addr_last", 32'(addr_q[3]), 32'h13);
    chk("rd4_bad_access", 32'(bad_acc), 32'd0);
    chk("rd4_done_cycle", 32'(done_cyc), 32'd6);
    chk("rd4_done_busy", 32'(done_busy), 32'd0);
    chk("rd4_checksum", cksum_a, 32'h0000000A);

    // Full-depth fill, then read the whole memory back.
    run_cmd(1'b0, 1'b1, 8'h00, 9'd256, 32'hA5A5A5A5, 300, 0);
    chk("fill_accesses", 32'(acc_n), 32'd256);
    chk("fill_bad_access", 32'(bad_acc), 32'd0);
    chk("fill_addr_last", 32'(addr_q[255]), 32'hFF);
    chk("fill_done_cycle", 32'(done_cyc), 32'd257);
    chk("fill_cksum_kept", cksum_a, 32'h0000000A);
    chk("fill_mem_80", mem_a[8'h80], 32'hA5A5A5A5);
    run_cmd(1'b0, 1'b0, 8'h00, 9'd256, 32'd0, 300, 0);
    chk("rdall_done_cycle", 32'(done_cyc), 32'd258);
    chk("rdall_checksum", cksum_a, 32'hA5A5A500);

    // Address wrap and 32-bit sum wrap.
    poke(1'b0, 8'hFE, 32'hFFFFFFFF); poke(1'b0, 8'hFF, 32'hFFFFFFFF);
    poke(1'b0, 8'h00, 32'hFFFFFFFF); poke(1'b0, 8'h01, 32'hFFFFFFFF);
    run_cmd(1'b0, 1'b0, 8'hFE, 9'd4, 32'd0, 40, 0);
    chk("wrap_addr1", 32'(addr_q[1]), 32'hFF);
    chk("wrap_addr2", 32'(addr_q[2]), 32'h00);
    chk("wrap_addr3", 32'(addr_q[3]), 32'h01);
    chk("wrap_checksum", cksum_a, 32'hFFFFFFFC);

    // Rejected lengths: 0 and DEPTH+1.
    sel = 1'b0; op = 1'b0; length = 9'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("len0_error", 32'(err_a), 32'd1);
    chk("len0_cs", 32'(cs_a), 32'd0);
    chk("len0_busy", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    chk("len0_error_pulse", 32'(err_a), 32'd0);
    length = 9'd257; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("len257_error", 32'(err_a), 32'd1);
    chk("len257_cs", 32'(cs_a), 32'd0);
    chk("len257_busy", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    chk("len257_error_pulse", 32'(err_a), 32'd0);
    chk("len257_cksum_kept", cksum_a, 32'hFFFFFFFC);

    // start during ISSUE must be ignored: 1+2+3+4 + 4*0xA5A5A5A5 = 0x9696969E.
    poke(1'b0, 8'h10, 32'd1); poke(1'b0, 8'h11, 32'd2);
    poke(1'b0, 8'h12, 32'd3); poke(1'b0, 8'h13, 32'd4);
    run_cmd(1'b0, 1'b0, 8'h10, 9'd8, 32'd0, 40, 3);
    chk("ign_accesses", 32'(acc_n), 32'd8);
    chk("ign_bad_access", 32'(bad_acc), 32'd0);
    chk("ign_addr_last", 32'(addr_q[7]), 32'h17);
    chk("ign_done_cycle", 32'(done_cyc), 32'd10);
    chk("ign_checksum", cksum_a, 32'h9696969E);
    chk("ign_mem_40", mem_a[8'h40], 32'hA5A5A5A5);

    // Reset in cycle 3 of a 16-word read.
    sel = 1'b0; op = 1'b0; base_addr = 8'h00; length = 9'd16; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_cs_before", 32'(cs_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_cs_async", 32'(cs_a), 32'd0);
    chk("mid_write_async", 32'(wr_a), 32'd0);
    chk("mid_checksum", cksum_a, 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    n_done = 0; n_cs = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_a) n_done++;
      if (cs_a) n_cs++;
      @(posedge clk); #1;
    end
    chk("mid_no_done", 32'(n_done), 32'd0);
    chk("mid_no_cs", 32'(n_cs), 32'd0);
    run_cmd(1'b0, 1'b0, 8'h10, 9'd4, 32'd0, 40, 0);
    chk("post_rst_done_cycle", 32'(done_cyc), 32'd6);
    chk("post_rst_checksum", cksum_a, 32'h0000000A);

    // Two-cycle read latency instance.
    poke(1'b1, 8'h20, 32'd5); poke(1'b1, 8'h21, 32'd6); poke(1'b1, 8'h22, 32'd7);
    run_cmd(1'b1, 1'b0, 8'h20, 9'd3, 32'd0, 40, 0);
    chk("rl2_accesses", 32'(acc_n), 32'd3);
    chk("rl2_done_cycle", 32'(done_cyc), 32'd6);
    chk("rl2_checksum", cksum_b, 32'h00000012);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
